spu_fx_pipe: RTL and testbench

Parametrised, pipelined successor to the SPU execute stage's simple fixed-point datapath. It accepts one issued instruction per cycle with pre-decoded operation, element size, immediate and destination tag. It computes a SIMD result across DATA_W bits and delivers it to register-file writeback after a fixed, configurable latency. Per-stage valid/tag outputs feed the issue unit's hazard and forwarding logic, and a flush input kills in-flight work on branch mispredict.

---
 rtl/spu_fx_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_spu_fx_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_fx_pipe.sv
// spu_fx_pipe: pipelined SIMD fixed-point execute datapath.
// An instruction is evaluated combinationally in its issue cycle and then
// carried through LATENCY stage registers to writeback. The per-stage valid
// bits and destination tags are exported for hazard detection and forwarding.
// stall freezes every stage, flush kills everything in flight, and reset
// clears all state.

module spu_fx_pipe #(
  parameter int DATA_W  = 128,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [3:0]                issue_op,
  input  logic                      issue_esize,
  input  logic                      issue_use_imm,
  input  logic [9:0]                issue_imm10,
  input  logic [ADDR_W-1:0]         issue_rt_addr,
  input  logic [DATA_W-1:0]         ra,
  input  logic [DATA_W-1:0]         rb,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      wb_valid,
  output logic [ADDR_W-1:0]         wb_rt_addr,
  output logic [DATA_W-1:0]         wb_result,
  output logic                      wb_illegal,
  output logic [LATENCY-1:0]        stage_valid,
  output logic [LATENCY*ADDR_W-1:0] stage_rt_addr,
  output logic                      busy
);

  localparam int NUM_WORDS = DATA_W / 32;
  localparam int NUM_HALVES = DATA_W / 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SF   = 4'd1,
    OP_AND  = 4'd2,
    OP_ANDC = 4'd3,
    OP_OR   = 4'd4,
    OP_ORC  = 4'd5,
    OP_XOR  = 4'd6,
    OP_NAND = 4'd7,
    OP_NOR  = 4'd8,
    OP_CEQ  = 4'd9,
    OP_CGT  = 4'd10,
    OP_CLGT = 4'd11,
    OP_CLZ  = 4'd12
  } op_e;

  // Leading-zero count of one 32-bit word; an all-zero word yields 32.
  function automatic logic [5:0] clz32(input logic [31:0] w);
    logic [5:0] n;
    logic       found;
    n = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && w[i]) begin
        n = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  op_e               op;
  logic [31:0]       imm_word;
  logic [15:0]       imm_half;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] half_res;
  logic [DATA_W-1:0] word_res;
  logic [DATA_W-1:0] issue_result;
  logic              issue_illegal;

  assign op = op_e'(issue_op);
  assign imm_word = {{22{issue_imm10[9]}}, issue_imm10};
  assign imm_half = imm_word[15:0];
  assign issue_illegal = (issue_op >= 4'd13);

  // Select operand B: the register value or the immediate replicated per element.
  always_comb begin
    opnd_b = rb;
    if (issue_use_imm) begin
      if (issue_esize) begin
        opnd_b = {NUM_WORDS{imm_word}};
      end else begin
        opnd_b = {NUM_HALVES{imm_half}};
      end
    end
  end

  // Arithmetic and compare results treating the operands as halfword lanes.
  always_comb begin
    half_res = '0;
    for (int h = 0; h < NUM_HALVES; h++) begin
      logic [15:0] ah;
      logic [15:0] bh;
      ah = ra[h*16 +: 16];
      bh = opnd_b[h*16 +: 16];
      case (op)
        OP_ADD:  half_res[h*16 +: 16] = ah + bh;
        OP_SF:   half_res[h*16 +: 16] = bh - ah;
        OP_CEQ:  half_res[h*16 +: 16] = {16{ah == bh}};
        OP_CGT:  half_res[h*16 +: 16] = {16{$signed(ah) > $signed(bh)}};
        OP_CLGT: half_res[h*16 +: 16] = {16{ah > bh}};
        default: half_res[h*16 +: 16] = 16'h0000;
      endcase
    end
  end

  // Arithmetic, compare and count-leading-zeros results on word lanes.
  always_comb begin
    word_res = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      logic [31:0] aw;
      logic [31:0] bw;
      aw = ra[w*32 +: 32];
      bw = opnd_b[w*32 +: 32];
      case (op)
        OP_ADD:  word_res[w*32 +: 32] = aw + bw;
        OP_SF:   word_res[w*32 +: 32] = bw - aw;
        OP_CEQ:  word_res[w*32 +: 32] = {32{aw == bw}};
        OP_CGT:  word_res[w*32 +: 32] = {32{$signed(aw) > $signed(bw)}};
        OP_CLGT: word_res[w*32 +: 32] = {32{aw > bw}};
        OP_CLZ:  word_res[w*32 +: 32] = {26'd0, clz32(aw)};
        default: word_res[w*32 +: 32] = 32'h0000_0000;
      endcase
    end
  end

  // Final result mux: lane-width ops pick by element size, logicals are lane-agnostic,
  // CLZ is always word based, and illegal encodings produce zero.
  always_comb begin
    issue_result = '0;
    case (op)
      OP_ADD, OP_SF, OP_CEQ, OP_CGT, OP_CLGT:
        issue_result = issue_esize ? word_res : half_res;
      OP_AND:  issue_result = ra & opnd_b;
      OP_ANDC: issue_result = ra & ~opnd_b;
      OP_OR:   issue_result = ra | opnd_b;
      OP_ORC:  issue_result = ra | ~opnd_b;
      OP_XOR:  issue_result = ra ^ opnd_b;
      OP_NAND: issue_result = ~(ra & opnd_b);
      OP_NOR:  issue_result = ~(ra | opnd_b);
      OP_CLZ:  issue_result = word_res;
      default: issue_result = '0;
    endcase
  end

  logic [LATENCY-1:0] st_valid;
  logic [LATENCY-1:0] st_illegal;
  logic [ADDR_W-1:0]  st_addr [LATENCY];
  logic [DATA_W-1:0]  st_res  [LATENCY];

  // Stage registers. Reset beats flush, flush beats stall, and a stalled cycle
  // neither captures the issue slot nor advances the older stages. Bubbles still
  // load their tag so the exported destination tags are always defined.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_valid   <= '0;
      st_illegal <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        st_addr[k] <= '0;
        st_res[k]  <= '0;
      end
    end else if (flush) begin
      st_valid <= '0;
    end else if (!stall) begin
      st_valid[0]   <= issue_valid;
      st_illegal[0] <= issue_illegal;
      st_addr[0]    <= issue_rt_addr;
      st_res[0]     <= issue_result;
      for (int k = 1; k < LATENCY; k++) begin
        st_valid[k]   <= st_valid[k-1];
        st_illegal[k] <= st_illegal[k-1];
        st_addr[k]    <= st_addr[k-1];
        st_res[k]     <= st_res[k-1];
      end
    end
  end

  // Pack per-stage tags for the issue unit; stage 0 is the youngest.
  always_comb begin
    stage_rt_addr = '0;
    for (int k = 0; k < LATENCY; k++) begin
      stage_rt_addr[k*ADDR_W +: ADDR_W] = st_addr[k];
    end
  end

  assign stage_valid = st_valid;
  assign busy        = |st_valid;

  // The oldest stage is presented to writeback, suppressed while it is held by a
  // stall (so it is written once, after release) or being killed by a flush.
  assign wb_valid   = st_valid[LATENCY-1] & ~stall & ~flush;
  assign wb_rt_addr = st_addr[LATENCY-1];
  assign wb_result  = st_res[LATENCY-1];
  assign wb_illegal = st_illegal[LATENCY-1];

endmodule

// File: tb/tb_spu_fx_pipe.sv
// tb_spu_fx_pipe: directed scoreboard bench for spu_fx_pipe (DATA_W=128, LATENCY=2).
// Expected writebacks are queued when an instruction is issued and checked
// against the DUT when wb_valid is seen on the falling edge.

module tb_spu_fx_pipe;

  localparam int DATA_W  = 128;
  localparam int LATENCY = 2;
  localparam int ADDR_W  = 7;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] res;
    logic              ill;
  } exp_t;

  logic                      clk;
  logic                      reset;
  logic                      issue_valid;
  logic [3:0]                issue_op;
  logic                      issue_esize;
  logic                      issue_use_imm;
  logic [9:0]                issue_imm10;
  logic [ADDR_W-1:0]         issue_rt_addr;
  logic [DATA_W-1:0]         ra;
  logic [DATA_W-1:0]         rb;
  logic                      stall;
  logic                      flush;
  logic                      wb_valid;
  logic [ADDR_W-1:0]         wb_rt_addr;
  logic [DATA_W-1:0]         wb_result;
  logic                      wb_illegal;
  logic [LATENCY-1:0]        stage_valid;
  logic [LATENCY*ADDR_W-1:0] stage_rt_addr;
  logic                      busy;

  exp_t exp_q[$];
  int   compares = 0;
  int   errors   = 0;

  spu_fx_pipe #(.DATA_W(DATA_W), .LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_op(issue_op),
    .issue_esize(issue_esize),
    .issue_use_imm(issue_use_imm),
    .issue_imm10(issue_imm10),
    .issue_rt_addr(issue_rt_addr),
    .ra(ra),
    .rb(rb),
    .stall(stall),
    .flush(flush),
    .wb_valid(wb_valid),
    .wb_rt_addr(wb_rt_addr),
    .wb_result(wb_result),
    .wb_illegal(wb_illegal),
    .stage_valid(stage_valid),
    .stage_rt_addr(stage_rt_addr),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    compares++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one instruction, let it be captured at the next rising edge, and
  // optionally record the writeback it must eventually produce.
  task automatic applyStimulus(input logic [3:0] op, input logic esize, input logic use_imm,
                               input logic [9:0] imm, input logic [ADDR_W-1:0] tag,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [DATA_W-1:0] exp_res, input logic exp_ill,
                               input logic push);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_esize   = esize;
    issue_use_imm = use_imm;
    issue_imm10   = imm;
    issue_rt_addr = tag;
    ra            = a;
    rb            = b;
    if (push) exp_q.push_back('{addr: tag, res: exp_res, ill: exp_ill});
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  // Writeback monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_wb", {{(DATA_W-ADDR_W){1'b0}}, wb_rt_addr}, '1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("wb_rt_addr", {{(DATA_W-ADDR_W){1'b0}}, wb_rt_addr},
                    {{(DATA_W-ADDR_W){1'b0}}, e.addr});
        checkOutput("wb_result", wb_result, e.res);
        checkOutput("wb_illegal", {{(DATA_W-1){1'b0}}, wb_illegal},
                    {{(DATA_W-1){1'b0}}, e.ill});
      end
    end
  end

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0;
    issue_op = 4'd0;
    issue_esize = 1'b0;
    issue_use_imm = 1'b0;
    issue_imm10 = 10'd0;
    issue_rt_addr = '0;
    ra = '0;
    rb = '0;
    stall = 1'b0;
    flush = 1'b0;

    // Reset state
    idle(3);
    @(negedge clk);
    checkOutput("rst_wb_valid", {127'd0, wb_valid}, 128'd0);
    checkOutput("rst_wb_illegal", {127'd0, wb_illegal}, 128'd0);
    checkOutput("rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("rst_stage_valid", {126'd0, stage_valid}, 128'd0);
    checkOutput("rst_wb_result", wb_result, 128'd0);
    checkOutput("rst_wb_rt_addr", {121'd0, wb_rt_addr}, 128'd0);
    checkOutput("rst_stage_rt_addr", {114'd0, stage_rt_addr}, 128'd0);
    idle(1);
    reset = 1'b0;
    idle(1);

    // ADD word with latency check
    applyStimulus(4'd0, 1'b1, 1'b0, 10'd0, 7'h11, {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}},
                  {4{32'h8000_0000}}, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("lat_stage_valid_1", {126'd0, stage_valid}, 128'd1);
    checkOutput("lat_wb_early", {127'd0, wb_valid}, 128'd0);
    checkOutput("lat_stage0_tag", {121'd0, stage_rt_addr[6:0]}, 128'h11);
    @(negedge clk);
    checkOutput("lat_wb_on_time", {127'd0, wb_valid}, 128'd1);
    @(negedge clk);
    checkOutput("lat_wb_one_wide", {127'd0, wb_valid}, 128'd0);
    checkOutput("lat_busy_empty", {127'd0, busy}, 128'd0);
    idle(1);

    // Datapath ops, issued back to back
    applyStimulus(4'd1, 1'b0, 1'b1, 10'h3FF, 7'h12, {8{16'h0005}}, '0, {8{16'hFFFA}}, 1'b0, 1'b1);
    applyStimulus(4'd1, 1'b1, 1'b1, 10'h3FF, 7'h13, {4{32'h0000_0005}}, '0, {4{32'hFFFF_FFFA}}, 1'b0, 1'b1);
    applyStimulus(4'd10, 1'b0, 1'b0, 10'd0, 7'h14, {8{16'hFFFF}}, {8{16'h0001}}, 128'd0, 1'b0, 1'b1);
    applyStimulus(4'd11, 1'b0, 1'b0, 10'd0, 7'h15, {8{16'hFFFF}}, {8{16'h0001}}, {8{16'hFFFF}}, 1'b0, 1'b1);
    applyStimulus(4'd9, 1'b0, 1'b0, 10'd0, 7'h16, {8{16'hFFFF}}, {8{16'hFFFF}}, {8{16'hFFFF}}, 1'b0, 1'b1);
    applyStimulus(4'd12, 1'b0, 1'b0, 10'd0, 7'h17,
                  {32'h0000_F000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000}, {4{32'hFFFF_FFFF}},
                  {32'd16, 32'd0, 32'd31, 32'd32}, 1'b0, 1'b1);
    applyStimulus(4'd14, 1'b1, 1'b0, 10'd0, 7'h18, {4{32'h1234_5678}}, {4{32'h1111_1111}},
                  128'd0, 1'b1, 1'b1);
    applyStimulus(4'd5, 1'b1, 1'b0, 10'd0, 7'h19, '0, {4{32'h0F0F_0F0F}}, {4{32'hF0F0_F0F0}}, 1'b0, 1'b1);
    applyStimulus(4'd2, 1'b1, 1'b1, 10'h200, 7'h1A, {4{32'hFFFF_FFFF}}, '0, {4{32'hFFFF_FE00}}, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b0, 1'b1, 10'h1FF, 7'h1B, {8{16'hFFFF}}, '0, {8{16'h01FE}}, 1'b0, 1'b1);
    applyStimulus(4'd6, 1'b1, 1'b0, 10'd0, 7'h1C, {4{32'hA5A5_5A5A}}, {4{32'hFFFF_0000}},
                  {4{32'h5A5A_5A5A}}, 1'b0, 1'b1);
    applyStimulus(4'd8, 1'b1, 1'b0, 10'd0, 7'h1D, {4{32'hF000_0000}}, {4{32'h0000_000F}},
                  {4{32'h0FFF_FFF0}}, 1'b0, 1'b1);
    idle(4);
    checkOutput("ops_drained", {96'd0, 32'(exp_q.size())}, 128'd0);

    // Stall for three cycles after the second of a back-to-back pair
    applyStimulus(4'd0, 1'b1, 1'b0, 10'd0, 7'd1, {4{32'd10}}, {4{32'd1}}, {4{32'd11}}, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b1, 1'b0, 10'd0, 7'd2, {4{32'd20}}, {4{32'd2}}, {4{32'd22}}, 1'b0, 1'b1);
    stall = 1'b1;
    issue_valid = 1'b1;
    issue_rt_addr = 7'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_wb_held", {127'd0, wb_valid}, 128'd0);
      checkOutput("stall_stages_held", {126'd0, stage_valid}, 128'd3);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    issue_valid = 1'b0;
    idle(3);
    checkOutput("stall_drained", {96'd0, 32'(exp_q.size())}, 128'd0);

    // Flush in the cycle tag 4 issues kills tags 3 and 4
    applyStimulus(4'd0, 1'b1, 1'b0, 10'd0, 7'd3, {4{32'd30}}, {4{32'd3}}, {4{32'd33}}, 1'b0, 1'b0);
    flush = 1'b1;
    applyStimulus(4'd0, 1'b1, 1'b0, 10'd0, 7'd4, {4{32'd40}}, {4{32'd4}}, {4{32'd44}}, 1'b0, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", {127'd0, busy}, 128'd0);
    idle(3);

    // Flush with an instruction at writeback suppresses it combinationally
    applyStimulus(4'd4, 1'b1, 1'b0, 10'd0, 7'h20, {4{32'h1}}, {4{32'h2}}, {4{32'h3}}, 1'b0, 1'b0);
    idle(1);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_wb_forced", {127'd0, wb_valid}, 128'd0);
    idle(1);
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush2_busy", {127'd0, busy}, 128'd0);
    idle(3);

    // Reset with two instructions in flight
    applyStimulus(4'd0, 1'b1, 1'b0, 10'd0, 7'd5, {4{32'd50}}, {4{32'd5}}, {4{32'd55}}, 1'b0, 1'b0);
    applyStimulus(4'd0, 1'b1, 1'b0, 10'd0, 7'd6, {4{32'd60}}, {4{32'd6}}, {4{32'd66}}, 1'b0, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_wb_valid", {127'd0, wb_valid}, 128'd0);
    checkOutput("mid_rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("mid_rst_stage_valid", {126'd0, stage_valid}, 128'd0);
    checkOutput("mid_rst_wb_result", wb_result, 128'd0);
    checkOutput("mid_rst_wb_rt_addr", {121'd0, wb_rt_addr}, 128'd0);
    checkOutput("mid_rst_wb_illegal", {127'd0, wb_illegal}, 128'd0);
    idle(5);

    checkOutput("final_queue_empty", {96'd0, 32'(exp_q.size())}, 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
